// File: rtl/julia_pixel_scan.sv
// Raster-order pixel source for the Julia-set pipeline: one token per handshake with
// screen x/y, initial z0 stepped incrementally in signed fixed point, and the frame's latched c.
module julia_pixel_scan #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = 32,
  parameter int FRAC_W     = 24,
  parameter int PIX_SHIFT  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [COORD_W-1:0]     c_real_in,
  input  logic signed [COORD_W-1:0]     c_imag_in,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
  output logic signed [COORD_W-1:0]     out_z_real,
  output logic signed [COORD_W-1:0]     out_z_imag,
  output logic signed [COORD_W-1:0]     out_c_real,
  output logic signed [COORD_W-1:0]     out_c_imag,
  output logic                          out_last
);

  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);

  localparam longint STEP_L = longint'(1) << (FRAC_W - PIX_SHIFT);
  localparam longint HALF_W_L = longint'(IMG_WIDTH / 2) * STEP_L;
  localparam longint HALF_H_L = longint'(IMG_HEIGHT / 2) * STEP_L;
  localparam longint LIM_L = longint'(1) << (COORD_W - 1);

  localparam logic signed [COORD_W-1:0] STEP = COORD_W'(STEP_L);
  localparam logic signed [COORD_W-1:0] X0   = COORD_W'(-HALF_W_L);
  localparam logic signed [COORD_W-1:0] Y0   = COORD_W'(-HALF_H_L);

  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_HEIGHT - 1);
  localparam logic FIRST_IS_LAST = (IMG_WIDTH == 1) && (IMG_HEIGHT == 1);

  // The half-frame offset must be representable as a signed COORD_W value.
  if (COORD_W > 63 || FRAC_W < PIX_SHIFT || HALF_W_L >= LIM_L || HALF_H_L >= LIM_L) begin : g_cfg_err
    $error("julia_pixel_scan: half-frame offset overflows COORD_W");
  end

  // Plain two's-complement step; the coordinate range never wraps for a legal configuration.
  function automatic logic signed [COORD_W-1:0] coord_step(input logic signed [COORD_W-1:0] a);
    return a + STEP;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_vld_p0;
  logic                        r_last_p0;
  logic [X_W-1:0]              r_x_p0;
  logic [Y_W-1:0]              r_y_p0;
  logic signed [COORD_W-1:0]   r_zr_p0;
  logic signed [COORD_W-1:0]   r_zi_p0;
  logic signed [COORD_W-1:0]   r_cr_p0;
  logic signed [COORD_W-1:0]   r_ci_p0;

  logic           w_xfer;
  logic           w_eol;
  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] w_y_nxt;
  logic           w_last_nxt;

  assign w_xfer     = r_vld_p0 & out_ready;
  assign w_eol      = (r_x_p0 == X_MAX);
  assign w_x_nxt    = w_eol ? '0 : X_W'(r_x_p0 + 1'b1);
  assign w_y_nxt    = w_eol ? Y_W'(r_y_p0 + 1'b1) : r_y_p0;
  assign w_last_nxt = (w_x_nxt == X_MAX) && (w_y_nxt == Y_MAX);

  // ---- stage p0: token register, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_x_p0    <= '0;
      r_y_p0    <= '0;
      r_zr_p0   <= '0;
      r_zi_p0   <= '0;
      r_cr_p0   <= '0;
      r_ci_p0   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cr_p0   <= c_real_in;
            r_ci_p0   <= c_imag_in;
            r_x_p0    <= '0;
            r_y_p0    <= '0;
            r_zr_p0   <= X0;
            r_zi_p0   <= Y0;
            r_last_p0 <= FIRST_IS_LAST;
            r_vld_p0  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_last_p0) begin
              r_vld_p0  <= 1'b0;
              r_last_p0 <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_x_p0    <= w_x_nxt;
              r_y_p0    <= w_y_nxt;
              r_last_p0 <= w_last_nxt;
              // Line wrap reloads the left edge exactly instead of subtracting a line's worth.
              if (w_eol) begin
                r_zr_p0 <= X0;
                r_zi_p0 <= coord_step(r_zi_p0);
              end else begin
                r_zr_p0 <= coord_step(r_zr_p0);
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_done;
  assign out_valid  = r_vld_p0;
  assign out_last   = r_last_p0;
  assign out_x      = r_x_p0;
  assign out_y      = r_y_p0;
  assign out_z_real = r_zr_p0;
  assign out_z_imag = r_zi_p0;
  assign out_c_real = r_cr_p0;
  assign out_c_imag = r_ci_p0;

endmodule

// File: tb/tb_julia_pixel_scan.sv
// Bench for julia_pixel_scan: a reduced-size instance drives a token scoreboard over
// full frames; a default-size instance covers first-token values and mid-frame reset.
module tb_julia_pixel_scan;

  localparam int CW = 32;
  localparam int SW = 12;
  localparam int SH = 5;
  localparam int BW = 640;
  localparam int BH = 480;
  localparam longint STEP = 64'h2_0000;
  localparam int SXW = $clog2(SW);
  localparam int SYW = $clog2(SH);
  localparam int BXW = $clog2(BW);
  localparam int BYW = $clog2(BH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // reduced-size instance
  logic s_reset, s_start, s_ready, s_rand;
  logic [CW-1:0] s_cr_in, s_ci_in;
  logic s_busy, s_done, s_valid, s_last;
  logic [SXW-1:0] s_x;
  logic [SYW-1:0] s_y;
  logic [CW-1:0] s_zr, s_zi, s_cr, s_ci;

  // default-size instance
  logic b_reset, b_start, b_ready;
  logic [CW-1:0] b_cr_in, b_ci_in;
  logic b_busy, b_done, b_valid, b_last;
  logic [BXW-1:0] b_x;
  logic [BYW-1:0] b_y;
  logic [CW-1:0] b_zr, b_zi, b_cr, b_ci;

  julia_pixel_scan #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start),
    .c_real_in(s_cr_in), .c_imag_in(s_ci_in),
    .busy(s_busy), .frame_done(s_done), .out_valid(s_valid), .out_ready(s_ready),
    .out_x(s_x), .out_y(s_y), .out_z_real(s_zr), .out_z_imag(s_zi),
    .out_c_real(s_cr), .out_c_imag(s_ci), .out_last(s_last)
  );

  julia_pixel_scan dut_b (
    .clk(clk), .reset(b_reset), .start(b_start),
    .c_real_in(b_cr_in), .c_imag_in(b_ci_in),
    .busy(b_busy), .frame_done(b_done), .out_valid(b_valid), .out_ready(b_ready),
    .out_x(b_x), .out_y(b_y), .out_z_real(b_zr), .out_z_imag(b_zi),
    .out_c_real(b_cr), .out_c_imag(b_ci), .out_last(b_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] x, y, zr, zi, cr, ci, last;
  } tok_t;

  tok_t sb[$];

  function automatic logic [CW-1:0] zexp(input int p, input int half);
    longint v;
    v = (longint'(p) - longint'(half)) * STEP;
    return v[CW-1:0];
  endfunction

  task automatic push_frame(input logic [CW-1:0] cr, input logic [CW-1:0] ci);
    tok_t t;
    for (int yy = 0; yy < SH; yy++) begin
      for (int xx = 0; xx < SW; xx++) begin
        t.x    = 64'(xx);
        t.y    = 64'(yy);
        t.zr   = 64'(zexp(xx, SW / 2));
        t.zi   = 64'(zexp(yy, SH / 2));
        t.cr   = 64'(cr);
        t.ci   = 64'(ci);
        t.last = 64'((xx == SW - 1) && (yy == SH - 1));
        sb.push_back(t);
      end
    end
  endtask

  task automatic cmp_tok(input string pfx, input tok_t a, input tok_t e);
    chk_eq({pfx, "_x"}, a.x, e.x);
    chk_eq({pfx, "_y"}, a.y, e.y);
    chk_eq({pfx, "_zr"}, a.zr, e.zr);
    chk_eq({pfx, "_zi"}, a.zi, e.zi);
    chk_eq({pfx, "_cr"}, a.cr, e.cr);
    chk_eq({pfx, "_ci"}, a.ci, e.ci);
    chk_eq({pfx, "_last"}, a.last, e.last);
  endtask

  // Ready driver for the reduced instance: always-ready or random stalls.
  initial begin
    s_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_ready = s_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Scoreboard monitor for the reduced instance.
  tok_t s_cur, s_snap, s_exp;
  logic s_pend = 1'b0;
  logic s_done_exp = 1'b0;
  int s_nxfer = 0;

  always @(negedge clk) begin
    if (s_reset) begin
      s_pend = 1'b0;
      s_done_exp = 1'b0;
    end else begin
      chk_eq("frame_done", 64'(s_done), 64'(s_done_exp));
      s_done_exp = 1'b0;
      s_cur.x = 64'(s_x);
      s_cur.y = 64'(s_y);
      s_cur.zr = 64'(s_zr);
      s_cur.zi = 64'(s_zi);
      s_cur.cr = 64'(s_cr);
      s_cur.ci = 64'(s_ci);
      s_cur.last = 64'(s_last);
      if (s_pend) begin
        chk_eq("stall_valid", 64'(s_valid), 64'd1);
        cmp_tok("stall", s_cur, s_snap);
      end
      s_pend = 1'b0;
      if (s_valid && s_ready) begin
        chk_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          s_exp = sb.pop_front();
          cmp_tok("tok", s_cur, s_exp);
        end
        s_nxfer++;
        if (s_last) s_done_exp = 1'b1;
      end else if (s_valid) begin
        s_pend = 1'b1;
        s_snap = s_cur;
      end
    end
  end

  task automatic s_frame_start(input logic [CW-1:0] cr, input logic [CW-1:0] ci);
    push_frame(cr, ci);
    @(posedge clk);
    #1;
    s_cr_in = cr;
    s_ci_in = ci;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    chk_eq("start_latency_valid", 64'(s_valid), 64'd1);
    chk_eq("start_latency_busy", 64'(s_busy), 64'd1);
  endtask

  task automatic wait_sdone(input int budget, output int vcyc);
    bit seen;
    seen = 1'b0;
    vcyc = 0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      if (s_valid) vcyc++;
      if (s_done) seen = 1'b1;
    end
    chk_eq("frame_done_seen", 64'(seen), 64'd1);
    if (seen) chk_eq("busy_in_done", 64'(s_busy), 64'd1);
    @(negedge clk);
    chk_eq("busy_after_done", 64'(s_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, x0;
    bit got;
    int i, tgt;
    s_rand = 1'b0;
    s_reset = 1'b1; s_start = 1'b1; s_cr_in = '1; s_ci_in = '1;
    b_reset = 1'b1; b_start = 1'b1; b_cr_in = '1; b_ci_in = '1; b_ready = 1'b1;

    // Reset with start held high: everything stays zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_s_busy", 64'(s_busy), 64'd0);
    chk_eq("rst_s_valid", 64'(s_valid), 64'd0);
    chk_eq("rst_s_done", 64'(s_done), 64'd0);
    chk_eq("rst_s_last", 64'(s_last), 64'd0);
    chk_eq("rst_s_xy", 64'({s_x, s_y}), 64'd0);
    chk_eq("rst_s_z", 64'({s_zr, s_zi}), 64'd0);
    chk_eq("rst_s_c", 64'({s_cr, s_ci}), 64'd0);
    chk_eq("rst_b_busy", 64'(b_busy), 64'd0);
    chk_eq("rst_b_valid", 64'(b_valid), 64'd0);
    chk_eq("rst_b_z", 64'({b_zr, b_zi}), 64'd0);
    chk_eq("rst_b_c", 64'({b_cr, b_ci}), 64'd0);
    @(posedge clk);
    #1;
    s_start = 1'b0; b_start = 1'b0;
    s_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    chk_eq("idle_s_valid", 64'(s_valid), 64'd0);

    // Full frame, always ready: one token per cycle, no bubbles.
    x0 = s_nxfer;
    s_frame_start(32'hFF4C_CCCD, 32'h0027_0A3D);
    wait_sdone(1000, vc);
    chk_eq("frame_valid_cycles", 64'(vc), 64'(SW * SH));
    chk_eq("frame_xfers", 64'(s_nxfer - x0), 64'(SW * SH));
    chk_eq("sb_drained_1", 64'(sb.size()), 64'd0);

    // Random consumer stalls.
    s_rand = 1'b1;
    x0 = s_nxfer;
    s_frame_start(32'h0123_4567, 32'h8765_4321);
    wait_sdone(2000, vc);
    chk_eq("stall_xfers", 64'(s_nxfer - x0), 64'(SW * SH));
    chk_eq("sb_drained_2", 64'(sb.size()), 64'd0);

    // Start and c toggled during the frame are ignored.
    s_frame_start(32'h00AA_5500, 32'hFFF0_0010);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      s_start = ~s_start;
      s_cr_in = $urandom;
      s_ci_in = $urandom;
    end
    s_start = 1'b0;
    wait_sdone(2000, vc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_eq("no_restart_valid", 64'(s_valid), 64'd0);
    end
    chk_eq("sb_drained_3", 64'(sb.size()), 64'd0);

    // Back-to-back frames with start held high.
    push_frame(32'h0000_1111, 32'h0000_2222);
    push_frame(32'h0000_1111, 32'h0000_2222);
    @(posedge clk);
    #1;
    s_cr_in = 32'h0000_1111; s_ci_in = 32'h0000_2222; s_start = 1'b1;
    wait_sdone(2000, vc);
    chk_eq("b2b_gap_valid", 64'(s_valid), 64'd0);
    @(negedge clk);
    chk_eq("b2b_first_valid", 64'(s_valid), 64'd1);
    @(posedge clk);
    #1;
    s_start = 1'b0;
    wait_sdone(2000, vc);
    chk_eq("sb_drained_4", 64'(sb.size()), 64'd0);
    s_rand = 1'b0;

    // Default-size instance: first tokens, line wrap, reset at (100,50).
    @(posedge clk);
    #1;
    b_cr_in = 32'hFF4C_CCCD; b_ci_in = 32'h0027_0A3D; b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    tgt = 100 + 50 * BW;
    i = 0;
    got = 1'b0;
    for (int t = 0; t < 40000 && !got; t++) begin
      @(negedge clk);
      if (b_valid) begin
        if (i == 0) begin
          chk_eq("big_first_zr", 64'(b_zr), 64'h0000_0000_FD80_0000);
          chk_eq("big_first_zi", 64'(b_zi), 64'h0000_0000_FE20_0000);
          chk_eq("big_first_cr", 64'(b_cr), 64'h0000_0000_FF4C_CCCD);
          chk_eq("big_first_ci", 64'(b_ci), 64'h0000_0000_0027_0A3D);
        end
        chk_eq("big_x", 64'(b_x), 64'(i % BW));
        chk_eq("big_y", 64'(b_y), 64'(i / BW));
        chk_eq("big_zr", 64'(b_zr), 64'(zexp(i % BW, BW / 2)));
        chk_eq("big_zi", 64'(b_zi), 64'(zexp(i / BW, BH / 2)));
        if (i == tgt) got = 1'b1;
        else i++;
      end
    end
    chk_eq("big_reached_target", 64'(got), 64'd1);
    b_reset = 1'b1;
    @(negedge clk);
    chk_eq("midrst_valid", 64'(b_valid), 64'd0);
    chk_eq("midrst_busy", 64'(b_busy), 64'd0);
    chk_eq("midrst_done", 64'(b_done), 64'd0);
    chk_eq("midrst_xy", 64'({b_x, b_y}), 64'd0);
    @(posedge clk);
    #1;
    b_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_eq("midrst_no_done", 64'(b_done), 64'd0);
      chk_eq("midrst_idle_valid", 64'(b_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    b_cr_in = 32'h1234_5678; b_ci_in = 32'h9ABC_DEF0; b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    @(negedge clk);
    chk_eq("restart_valid", 64'(b_valid), 64'd1);
    chk_eq("restart_xy", 64'({b_x, b_y}), 64'd0);
    chk_eq("restart_zr", 64'(b_zr), 64'h0000_0000_FD80_0000);
    chk_eq("restart_cr", 64'(b_cr), 64'h0000_0000_1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
